// File: rtl/sink_valid_tracker_pkg.sv
// Shared widths and index type for the sink priority path.
// The encoder, this tracker and the sink mux all import these.
package sink_valid_tracker_pkg;

  localparam int unsigned NUM_SINKS      = 64;
  localparam int unsigned LOG2_NUM_SINKS = 6;
  localparam int unsigned CNT_W          = LOG2_NUM_SINKS + 1;

  typedef logic [LOG2_NUM_SINKS-1:0] sink_idx_t;
  typedef logic [NUM_SINKS-1:0]      sink_vec_t;
  typedef logic [CNT_W-1:0]          pend_cnt_t;

  // One-hot of a sink index.
  function automatic sink_vec_t idx_onehot(input sink_idx_t idx);
    sink_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sink_valid_tracker_popcount.sv
// Purely combinational population count of an N-bit vector.
module popcount_nbit #(
  parameter  int unsigned N = 64,
  localparam int unsigned W = $clog2(N + 1)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt = cnt + W'(vec[i]);
    end
  end

endmodule

// File: rtl/sink_valid_tracker.sv
// Pending-request vector for the lowest-index encoder, plus a one-entry
// selection register, outstanding count and sticky duplicate-request flag.
module sink_valid_tracker
  import sink_valid_tracker_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SINKS-1:0]      req_set,
  output logic [NUM_SINKS-1:0]      valids_r,
  input  logic [LOG2_NUM_SINKS-1:0] current_idx,
  output logic                      sel_valid,
  output logic [LOG2_NUM_SINKS-1:0] sel_idx,
  input  logic                      sel_ready,
  output logic [LOG2_NUM_SINKS:0]   pend_cnt,
  output logic                      ovf
);

  sink_vec_t valids_q, valids_d;
  logic      sel_valid_q, sel_valid_d;
  sink_idx_t sel_idx_q, sel_idx_d;
  pend_cnt_t pend_cnt_q, pend_cnt_d;
  logic      ovf_q, ovf_d;

  logic      any_c;
  logic      load_c;
  sink_vec_t clr_onehot_c;
  pend_cnt_t valids_cnt_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valids_q    <= '0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
      pend_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      valids_q    <= valids_d;
      sel_valid_q <= sel_valid_d;
      sel_idx_q   <= sel_idx_d;
      pend_cnt_q  <= pend_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Load decision; current_idx is only meaningful while any_c is high.
  always_comb begin
    any_c        = |valids_q;
    load_c       = any_c & (~sel_valid_q | sel_ready);
    clr_onehot_c = load_c ? idx_onehot(current_idx) : '0;
  end

  popcount_nbit #(.N(NUM_SINKS)) u_popcount (
    .vec (valids_d),
    .cnt (valids_cnt_c)
  );

  // Next-state: a fresh request on the bit being loaded survives the clear.
  always_comb begin
    valids_d    = (valids_q & ~clr_onehot_c) | req_set;
    sel_valid_d = sel_valid_q;
    sel_idx_d   = sel_idx_q;
    if (load_c) begin
      sel_valid_d = 1'b1;
      sel_idx_d   = current_idx;
    end else if (sel_valid_q && sel_ready) begin
      sel_valid_d = 1'b0;
    end
    ovf_d      = ovf_q | (|(req_set & valids_q & ~clr_onehot_c));
    pend_cnt_d = valids_cnt_c + CNT_W'(sel_valid_d);
  end

  // Outputs straight from flops.
  always_comb begin
    valids_r  = valids_q;
    sel_valid = sel_valid_q;
    sel_idx   = sel_idx_q;
    pend_cnt  = pend_cnt_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_sink_valid_tracker.sv
// Directed bench for sink_valid_tracker with a per-cycle reference model
// and hand-computed checkpoints.
module tb_sink_valid_tracker;

  logic        clk;
  logic        rst_n;
  logic [63:0] req_set;
  logic [63:0] valids_r;
  logic [5:0]  current_idx;
  logic        sel_valid;
  logic [5:0]  sel_idx;
  logic        sel_ready;
  logic [6:0]  pend_cnt;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  sink_valid_tracker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_set     (req_set),
    .valids_r    (valids_r),
    .current_idx (current_idx),
    .sel_valid   (sel_valid),
    .sel_idx     (sel_idx),
    .sel_ready   (sel_ready),
    .pend_cnt    (pend_cnt),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Parent-level lowest-index priority encoder.
  always_comb begin
    current_idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (valids_r[i]) current_idx = 6'(i);
    end
  end

  // Reference model: a set of pending sinks and a one-slot holding register.
  bit m_pend [64];
  bit m_sv;
  int m_si;
  bit m_ovf;
  int m_cnt;

  always @(posedge clk or negedge rst_n) begin : model
    bit found;
    bit ld;
    int lo;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_pend[i] = 1'b0;
      m_sv = 0; m_si = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      found = 0; lo = 0;
      for (int i = 0; i < 64; i++) begin
        if (m_pend[i] && !found) begin found = 1; lo = i; end
      end
      ld = found && (!m_sv || sel_ready);
      for (int i = 0; i < 64; i++) begin
        if (req_set[i] && m_pend[i] && !(ld && i == lo)) m_ovf = 1;
      end
      if (ld) m_pend[lo] = 0;
      for (int i = 0; i < 64; i++) begin
        if (req_set[i]) m_pend[i] = 1;
      end
      if (ld) begin
        m_sv = 1; m_si = lo;
      end else if (m_sv && sel_ready) begin
        m_sv = 0;
      end
      m_cnt = m_sv ? 1 : 0;
      for (int i = 0; i < 64; i++) m_cnt += m_pend[i] ? 1 : 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    logic [63:0] mv;
    if (rst_n) begin
      for (int i = 0; i < 64; i++) mv[i] = m_pend[i];
      total++;
      if (valids_r !== mv) begin
        bad++; $display("FAIL model_valids got=%h want=%h t=%0t", valids_r, mv, $time);
      end
      total++;
      if (sel_valid !== m_sv) begin
        bad++; $display("FAIL model_sel_valid got=%0b want=%0b t=%0t", sel_valid, m_sv, $time);
      end
      if (m_sv) begin
        total++;
        if (sel_idx !== 6'(m_si)) begin
          bad++; $display("FAIL model_sel_idx got=%0d want=%0d t=%0t", sel_idx, m_si, $time);
        end
      end
      total++;
      if (pend_cnt !== 7'(m_cnt)) begin
        bad++; $display("FAIL model_pend_cnt got=%0d want=%0d t=%0t", pend_cnt, m_cnt, $time);
      end
      total++;
      if (ovf !== m_ovf) begin
        bad++; $display("FAIL model_ovf got=%0b want=%0b t=%0t", ovf, m_ovf, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Snapshot of all five outputs against literal expectations.
  task automatic chk_all(input string name, input logic [63:0] v, input logic sv,
                         input int si, input int cnt, input logic o);
    chk({name, ".valids"}, valids_r, v);
    chk({name, ".sel_valid"}, 64'(sel_valid), 64'(sv));
    if (sv) chk({name, ".sel_idx"}, 64'(sel_idx), 64'(si));
    chk({name, ".pend_cnt"}, 64'(pend_cnt), 64'(cnt));
    chk({name, ".ovf"}, 64'(ovf), 64'(o));
  endtask

  task automatic pulse(input logic [63:0] v);
    req_set = v;
    tick();
    req_set = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_set   = '0;
    sel_ready = 1'b1;

    // Reset held for three cycles.
    repeat (3) tick();
    chk_all("reset", 64'h0, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single request on sink 0.
    pulse(64'h1);
    chk_all("s0_pend", 64'h1, 1'b0, 0, 1, 1'b0);
    tick();
    chk_all("s0_sel", 64'h0, 1'b1, 0, 1, 1'b0);
    tick();
    chk_all("s0_done", 64'h0, 1'b0, 0, 0, 1'b0);

    // Three requests drained back to back, lowest index first.
    pulse((64'h1 << 5) | (64'h1 << 9) | (64'h1 << 63));
    chk_all("b3_pend", (64'h1 << 5) | (64'h1 << 9) | (64'h1 << 63), 1'b0, 0, 3, 1'b0);
    tick();
    chk_all("b3_sel5", (64'h1 << 9) | (64'h1 << 63), 1'b1, 5, 3, 1'b0);
    tick();
    chk_all("b3_sel9", (64'h1 << 63), 1'b1, 9, 2, 1'b0);
    tick();
    chk_all("b3_sel63", 64'h0, 1'b1, 63, 1, 1'b0);
    tick();
    chk_all("b3_done", 64'h0, 1'b0, 0, 0, 1'b0);

    // Backpressure holds the selection and the remaining pending bit.
    sel_ready = 1'b0;
    pulse((64'h1 << 2) | (64'h1 << 7));
    tick();
    repeat (3) tick();
    chk_all("bp_hold", (64'h1 << 7), 1'b1, 2, 2, 1'b0);
    sel_ready = 1'b1;
    tick();
    chk_all("bp_sel7", 64'h0, 1'b1, 7, 1, 1'b0);
    tick();
    chk_all("bp_done", 64'h0, 1'b0, 0, 0, 1'b0);

    // Duplicate request on a pending sink raises sticky ovf and merges.
    sel_ready = 1'b0;
    pulse((64'h1 << 1) | (64'h1 << 4));
    tick();
    chk_all("ov_hold", (64'h1 << 4), 1'b1, 1, 2, 1'b0);
    pulse(64'h1 << 4);
    chk_all("ov_dup", (64'h1 << 4), 1'b1, 1, 2, 1'b1);
    sel_ready = 1'b1;
    tick();
    chk_all("ov_sel4", 64'h0, 1'b1, 4, 1, 1'b1);
    tick();
    chk_all("ov_once", 64'h0, 1'b0, 0, 0, 1'b1);
    tick();
    chk_all("ov_sticky", 64'h0, 1'b0, 0, 0, 1'b1);

    // Reset clears ovf before the re-request case.
    rst_n = 1'b0;
    #1;
    chk_all("rst_ovf", 64'h0, 1'b0, 0, 0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Re-request on the bit being loaded is a fresh request, not a duplicate.
    pulse(64'h1 << 3);
    chk_all("rr_pend", (64'h1 << 3), 1'b0, 0, 1, 1'b0);
    pulse(64'h1 << 3);
    chk_all("rr_first", (64'h1 << 3), 1'b1, 3, 2, 1'b0);
    tick();
    chk_all("rr_second", 64'h0, 1'b1, 3, 1, 1'b0);
    tick();
    chk_all("rr_done", 64'h0, 1'b0, 0, 0, 1'b0);

    // Asynchronous reset mid-transfer drops everything.
    sel_ready = 1'b0;
    pulse(64'h0000_0000_000F_FC00);
    chk_all("ar_pend", 64'h0000_0000_000F_FC00, 1'b0, 0, 10, 1'b0);
    tick();
    chk_all("ar_sel", 64'h0000_0000_000F_F800, 1'b1, 10, 10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("ar_async", 64'h0, 1'b0, 0, 0, 1'b0);
    tick();
    tick();
    rst_n     = 1'b1;
    sel_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all("ar_quiet", 64'h0, 1'b0, 0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
